div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one iterative divider (start/done handshake, multi-cycle) among N requesters.
- Rotating-priority arbitration; captures the winner's operands; sequences the divider; returns quotient/remainder tagged with requester ID over a valid/ready response port.
- Sits between client blocks and the single divider instance.

Parameters:
- N, 4, number of requesters (>=2)
- L, 16, dividend/quotient width
- l, 3, divisor/remainder width (l <= L)
- IDW, $clog2(N), requester ID width (derived; do not override)

Ports:
- Clk_i  in  1  clock, rising edge
- RstN_i  in  1  asynchronous active-low reset
- Req_i  in  N  per-requester request, held until granted
- Dividend_i  in  N*L  packed dividends, requester k at [k*L +: L]
- Divisor_i  in  N*l  packed divisors, requester k at [k*l +: l]
- Gnt_o  out  N  one-hot grant; operands captured on this edge
- Busy_o  out  1  high whenever state != IDLE
- RspValid_o  out  1  response valid
- RspReady_i  in  1  response accepted
- RspId_o  out  IDW  ID of the responding requester
- RspQ_o  out  L  quotient
- RspR_o  out  l  remainder
- RspDz_o  out  1  divide-by-zero flag (see Optional Feature)
- DivStart_o  out  1  single-cycle divider start pulse
- DivDividend_o  out  L  operand to divider
- DivDivisor_o  out  l  operand to divider
- DivDone_i  in  1  divider completion pulse
- DivQ_i  in  L  divider quotient
- DivA_i  in  L+1  divider remainder/accumulator

Behaviour:
- Reset (RstN_i low, async): state=IDLE, RR pointer=0, all outputs 0, operand/result registers 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any Req_i bit is set, grant the first set bit searching upward from the RR pointer, wrapping modulo N.
  - Gnt_o is combinational (Mealy) in IDLE only, one-hot, high for exactly one cycle.
  - On that edge: latch the winner's operands and ID; RR pointer <= ID+1 mod N; go to ISSUE.
  - Gnt_o is 0 in every other state.
- ISSUE: DivStart_o=1 for this cycle only -> WAIT.
- WAIT:
  - Sample DivDone_i only in this state.
  - On DivDone_i: RspQ_o <= DivQ_i; RspR_o <= DivA_i[l-1:0] (remainder < divisor, so upper bits are discarded); go to RESP.
  - No timeout; the arbiter waits indefinitely.
- RESP:
  - RspValid_o=1; RspId_o/RspQ_o/RspR_o/RspDz_o held stable until RspValid_o && RspReady_i.
  - On handshake -> IDLE. No new grant until then.
- DivDividend_o/DivDivisor_o are driven from the operand registers and held stable from ISSUE through WAIT.
- Latency: grant edge -> DivStart_o next cycle -> RspValid_o one cycle after DivDone_i. Minimum one idle cycle between back-to-back grants.
- Requesters may drop Req_i before grant; an un-granted request has no effect. Operands are sampled only on the grant cycle.
- A requester whose Req_i stays high after its response is re-arbitrated normally. The RR pointer guarantees every persistent requester is served within N grants.
- Reset mid-operation (any state): immediate return to reset values. Any pending response is lost. The system resets the divider on the same reset.
- DivDone_i outside WAIT is ignored.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN
- Defined: a granted request with divisor==0 goes IDLE -> RESP directly on the grant edge; DivStart_o is never asserted. Response is RspQ_o={L{1'b1}}, RspR_o=0, RspDz_o=1. Nonzero divisors follow the normal path with RspDz_o=0.
- Undefined: all requests use the divider; RspDz_o is tied 0; a zero divisor returns whatever the divider produces.

Test Plan:
- Single request: Req_i=4'b0001, dividend 100, divisor 7 -> one Gnt_o pulse 4'b0001; one DivStart_o pulse; RspId_o=0, RspQ_o=14, RspR_o=2, RspDz_o=0.
- All four request simultaneously after reset, each held -> grant order 0,1,2,3. Each response carries the correct ID and results (operands 60/3, 61/4, 62/5, 63/6 -> 20r0, 15r1, 12r2, 10r3).
- Req_i=4'b0101 held continuously for 6 grants -> grant sequence 0,2,0,2,0,2.
- RspReady_i held low 10 cycles in RESP -> RspValid_o high and all Rsp* outputs stable; Gnt_o=0; DivStart_o=0. Completes on the first RspReady_i high.
- RstN_i pulsed low during WAIT -> all outputs 0 asynchronously and no response issued. A request after reset release (dividend 9, divisor 2) returns Q=4, R=1.
- With DIV_ZERO_BYPASS_EN, requester 1 with divisor 0 -> RspValid_o one cycle after grant; RspQ_o=16'hFFFF, RspR_o=0, RspDz_o=1; DivStart_o never asserted. Without the macro, DivStart_o pulses and RspDz_o=0.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: rotating-priority arbiter sharing one iterative divider among N requesters (DIV_ZERO_BYPASS_EN answers x/0 locally)
module div_arbiter #(
  parameter int N = 4,
  parameter int L = 16,
  parameter int l = 3,
  localparam int IDW = $clog2(N)
) (
  input  logic             Clk_i,
  input  logic             RstN_i,
  input  logic [N-1:0]     Req_i,
  input  logic [N*L-1:0]   Dividend_i,
  input  logic [N*l-1:0]   Divisor_i,
  output logic [N-1:0]     Gnt_o,
  output logic             Busy_o,
  output logic             RspValid_o,
  input  logic             RspReady_i,
  output logic [IDW-1:0]   RspId_o,
  output logic [L-1:0]     RspQ_o,
  output logic [l-1:0]     RspR_o,
  output logic             RspDz_o,
  output logic             DivStart_o,
  output logic [L-1:0]     DivDividend_o,
  output logic [l-1:0]     DivDivisor_o,
  input  logic             DivDone_i,
  input  logic [L-1:0]     DivQ_i,
  input  logic [L:0]       DivA_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, win_id, cand, rr_next;
  logic [L-1:0] win_dividend;
  logic [l-1:0] win_divisor;
  logic win_found, unused_rem_hi;
  // first requesting index at or above the rotating pointer, wrapping
  always_comb begin
    win_id = '0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDW'((int'(rr_ptr) + i) % N);
      if (Req_i[cand]) win_id = cand;
    end
  end
  assign win_found = |Req_i;
  assign win_dividend = Dividend_i[win_id*L +: L];
  assign win_divisor = Divisor_i[win_id*l +: l];
  assign rr_next = (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
  assign Gnt_o = (RstN_i && state == IDLE && win_found) ? N'(1) << win_id : '0;
  assign unused_rem_hi = ^DivA_i[L:l];
  // arbitration / divider sequencing / response FSM with registered outputs
  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      Busy_o <= 1'b0;
      RspValid_o <= 1'b0;
      RspId_o <= '0;
      RspQ_o <= '0;
      RspR_o <= '0;
      RspDz_o <= 1'b0;
      DivStart_o <= 1'b0;
      DivDividend_o <= '0;
      DivDivisor_o <= '0;
    end else begin
      case (state)
        IDLE: if (win_found) begin
          rr_ptr <= rr_next;
          RspId_o <= win_id;
          DivDividend_o <= win_dividend;
          DivDivisor_o <= win_divisor;
          Busy_o <= 1'b1;
          RspDz_o <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
          if (win_divisor == '0) begin
            state <= RESP;
            RspValid_o <= 1'b1;
            RspQ_o <= '1;
            RspR_o <= '0;
            RspDz_o <= 1'b1;
          end else begin
            state <= ISSUE;
            DivStart_o <= 1'b1;
          end
`else
          state <= ISSUE;
          DivStart_o <= 1'b1;
`endif
        end
        ISSUE: begin
          DivStart_o <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (DivDone_i) begin
          RspQ_o <= DivQ_i;
          RspR_o <= DivA_i[l-1:0];
          RspValid_o <= 1'b1;
          state <= RESP;
        end
        RESP: if (RspReady_i) begin
          RspValid_o <= 1'b0;
          Busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: vector table, corner sequences and random traffic against a rule-level arbiter/divider model
module tb_div_arbiter;
  localparam int N = 4;
  localparam int L = 16;
  localparam int LW = 3;
  logic Clk_i = 1'b0;
  logic RstN_i;
  logic [N-1:0] Req_i;
  logic [N*L-1:0] Dividend_i;
  logic [N*LW-1:0] Divisor_i;
  logic [N-1:0] Gnt_o;
  logic Busy_o, RspValid_o, RspReady_i, RspDz_o, DivStart_o, DivDone_i;
  logic [1:0] RspId_o;
  logic [L-1:0] RspQ_o, DivDividend_o, DivQ_i;
  logic [LW-1:0] RspR_o, DivDivisor_o;
  logic [L:0] DivA_i;
  int pass_cnt = 0;
  int total_cnt = 0;
  int div_lat = 2;
  int starts = 0;
  bit spur = 1'b0;

  div_arbiter #(.N(N), .L(L), .l(LW)) dut (
    .Clk_i(Clk_i), .RstN_i(RstN_i), .Req_i(Req_i), .Dividend_i(Dividend_i), .Divisor_i(Divisor_i),
    .Gnt_o(Gnt_o), .Busy_o(Busy_o), .RspValid_o(RspValid_o), .RspReady_i(RspReady_i),
    .RspId_o(RspId_o), .RspQ_o(RspQ_o), .RspR_o(RspR_o), .RspDz_o(RspDz_o),
    .DivStart_o(DivStart_o), .DivDividend_o(DivDividend_o), .DivDivisor_o(DivDivisor_o),
    .DivDone_i(DivDone_i), .DivQ_i(DivQ_i), .DivA_i(DivA_i)
  );

  always #5 Clk_i = ~Clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // divider stand-in: captures operands on start, answers after div_lat cycles
  initial begin
    bit d_busy;
    int d_cnt;
    logic [L-1:0] d_a;
    logic [LW-1:0] d_b;
    d_busy = 0; d_cnt = 0; d_a = '0; d_b = '0;
    DivDone_i = 1'b0; DivQ_i = '0; DivA_i = '0;
    forever begin
      @(posedge Clk_i); #1;
      DivDone_i = 1'b0;
      if (!RstN_i) d_busy = 0;
      else if (d_busy) begin
        if (d_cnt == 0) begin
          DivDone_i = 1'b1;
          DivQ_i = (d_b == 0) ? '1 : d_a / L'(d_b);
          DivA_i = (d_b == 0) ? {1'b0, d_a} : (L+1)'(d_a % L'(d_b));
          d_busy = 0;
        end else d_cnt--;
      end else if (spur) begin
        DivDone_i = 1'b1; DivQ_i = 16'h5a5a; DivA_i = 17'h3; spur = 1'b0;
      end
      if (RstN_i && DivStart_o) begin
        d_busy = 1; d_cnt = div_lat; d_a = DivDividend_o; d_b = DivDivisor_o; starts++;
      end
    end
  end

  // reference model: one outstanding job, rotating pointer, arithmetic results
  initial begin
    bit m_busy;
    int m_ptr, w, e_id;
    logic [L-1:0] a, e_q;
    logic [LW-1:0] b, e_r;
    logic e_dz;
    m_busy = 0; m_ptr = 0; e_id = 0; e_q = '0; e_r = '0; e_dz = 0;
    forever begin
      @(negedge Clk_i);
      if (!RstN_i) begin
        m_busy = 0; m_ptr = 0;
      end else if (RspValid_o && RspReady_i) begin
        chk("mon_rsp_expected", 32'(m_busy), 1);
        chk("mon_rsp_id", 32'(RspId_o), e_id);
        chk("mon_rsp_q", 32'(RspQ_o), 32'(e_q));
        chk("mon_rsp_r", 32'(RspR_o), 32'(e_r));
        chk("mon_rsp_dz", 32'(RspDz_o), 32'(e_dz));
        m_busy = 0;
      end else if (!m_busy && Req_i != 0) begin
        w = -1;
        for (int i = 0; i < N; i++) if (w < 0 && Req_i[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        chk("mon_gnt", 32'(Gnt_o), 32'(1) << w);
        a = Dividend_i[w*L +: L];
        b = Divisor_i[w*LW +: LW];
        e_id = w;
        if (b != 0) begin
          e_q = a / L'(b); e_r = LW'(a % L'(b)); e_dz = 0;
        end else begin
`ifdef DIV_ZERO_BYPASS_EN
          e_q = '1; e_r = '0; e_dz = 1;
`else
          e_q = '1; e_r = a[LW-1:0]; e_dz = 0;
`endif
        end
        m_busy = 1;
        m_ptr = (w + 1) % N;
      end else chk("mon_gnt_zero", 32'(Gnt_o), 0);
    end
  end

  task automatic step();
    @(posedge Clk_i); #1;
  endtask

  task automatic set_ops(input int k, input logic [L-1:0] a, input logic [LW-1:0] b);
    Dividend_i[k*L +: L] = a;
    Divisor_i[k*LW +: LW] = b;
  endtask

  task automatic grab(output int id);
    bit ok = 0;
    id = -1;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge Clk_i);
      if (Gnt_o != 0) begin
        ok = 1;
        for (int k = 0; k < N; k++) if (Gnt_o[k]) id = k;
      end
    end
    chk("grant_seen", 32'(ok), 1);
  endtask

  task automatic wait_rsp();
    bit ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge Clk_i);
      ok = RspValid_o;
    end
    chk("rsp_seen", 32'(ok), 1);
  endtask

  task automatic do_reset();
    step();
    RstN_i = 1'b0;
    step();
    step();
    RstN_i = 1'b1;
    step();
  endtask

  typedef struct {
    int id;
    logic [L-1:0] a;
    logic [LW-1:0] b;
    logic [L-1:0] q;
    logic [LW-1:0] r;
  } vec_t;
  vec_t tv[6];
  logic [L-1:0] q4[4];
  logic [LW-1:0] r4[4];

  initial begin
    int id, s0;
    bit seen;
    tv[0] = '{0, 16'd100, 3'd7, 16'd14, 3'd2};
    tv[1] = '{2, 16'd9, 3'd2, 16'd4, 3'd1};
    tv[2] = '{3, 16'hFFFF, 3'd7, 16'd9362, 3'd1};
    tv[3] = '{1, 16'd0, 3'd5, 16'd0, 3'd0};
    tv[4] = '{2, 16'd1234, 3'd1, 16'd1234, 3'd0};
    tv[5] = '{0, 16'd6, 3'd7, 16'd0, 3'd6};
    q4 = '{16'd20, 16'd15, 16'd12, 16'd10};
    r4 = '{3'd0, 3'd1, 3'd2, 3'd3};
    RstN_i = 1'b0; Req_i = '1; RspReady_i = 1'b1; Dividend_i = '0; Divisor_i = '0;
    #3;
    chk("rst_gnt", 32'(Gnt_o), 0);
    chk("rst_busy", 32'(Busy_o), 0);
    chk("rst_valid", 32'(RspValid_o), 0);
    chk("rst_start", 32'(DivStart_o), 0);
    chk("rst_id", 32'(RspId_o), 0);
    chk("rst_q", 32'(RspQ_o), 0);
    chk("rst_r", 32'(RspR_o), 0);
    chk("rst_dz", 32'(RspDz_o), 0);
    chk("rst_dvd", 32'(DivDividend_o), 0);
    chk("rst_dvs", 32'(DivDivisor_o), 0);
    Req_i = '0;
    step();
    RstN_i = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      s0 = starts;
      set_ops(tv[i].id, tv[i].a, tv[i].b);
      Req_i[tv[i].id] = 1'b1;
      grab(id);
      chk("tbl_gnt", 32'(Gnt_o), 32'(1) << tv[i].id);
      step();
      Req_i = '0;
      chk("tbl_start", 32'(DivStart_o), 1);
      wait_rsp();
      chk("tbl_id", 32'(RspId_o), tv[i].id);
      chk("tbl_q", 32'(RspQ_o), 32'(tv[i].q));
      chk("tbl_r", 32'(RspR_o), 32'(tv[i].r));
      chk("tbl_dz", 32'(RspDz_o), 0);
      step();
      chk("tbl_done", 32'(RspValid_o), 0);
      chk("tbl_starts", starts - s0, 1);
    end
    do_reset();
    for (int k = 0; k < 4; k++) set_ops(k, L'(60 + k), LW'(3 + k));
    Req_i = '1;
    for (int n = 0; n < 4; n++) begin
      grab(id);
      chk("rr4_order", id, n);
      step();
      if (id >= 0) Req_i[id] = 1'b0;
      wait_rsp();
      chk("rr4_id", 32'(RspId_o), n);
      chk("rr4_q", 32'(RspQ_o), 32'(q4[n]));
      chk("rr4_r", 32'(RspR_o), 32'(r4[n]));
      step();
    end
    Req_i = '0;
    do_reset();
    set_ops(0, 16'd40, 3'd5);
    set_ops(2, 16'd41, 3'd6);
    Req_i = 4'b0101;
    for (int n = 0; n < 6; n++) begin
      grab(id);
      chk("rr2_order", id, (n % 2) * 2);
      step();
      wait_rsp();
      step();
    end
    Req_i = '0;
    set_ops(3, 16'd500, 3'd6);
    set_ops(0, 16'd7, 3'd7);
    RspReady_i = 1'b0;
    Req_i = 4'b1000;
    grab(id);
    chk("hold_gnt", id, 3);
    step();
    Req_i = 4'b0001;
    wait_rsp();
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk_i);
      chk("hold_valid", 32'(RspValid_o), 1);
      chk("hold_id", 32'(RspId_o), 3);
      chk("hold_q", 32'(RspQ_o), 83);
      chk("hold_r", 32'(RspR_o), 2);
      chk("hold_dz", 32'(RspDz_o), 0);
      chk("hold_nognt", 32'(Gnt_o), 0);
      chk("hold_nostart", 32'(DivStart_o), 0);
    end
    step();
    RspReady_i = 1'b1;
    @(negedge Clk_i);
    chk("hold_last", 32'(RspValid_o), 1);
    step();
    chk("hold_release", 32'(RspValid_o), 0);
    grab(id);
    chk("hold_next", id, 0);
    step();
    Req_i = '0;
    wait_rsp();
    chk("hold_next_q", 32'(RspQ_o), 1);
    chk("hold_next_r", 32'(RspR_o), 0);
    step();
    div_lat = 8;
    set_ops(2, 16'd1000, 3'd3);
    Req_i = 4'b0100;
    grab(id);
    step();
    Req_i = '0;
    step();
    step();
    chk("mid_busy", 32'(Busy_o), 1);
    chk("mid_dvd", 32'(DivDividend_o), 1000);
    #2 RstN_i = 1'b0;
    #1;
    chk("async_busy", 32'(Busy_o), 0);
    chk("async_valid", 32'(RspValid_o), 0);
    chk("async_start", 32'(DivStart_o), 0);
    chk("async_gnt", 32'(Gnt_o), 0);
    chk("async_id", 32'(RspId_o), 0);
    chk("async_dvd", 32'(DivDividend_o), 0);
    chk("async_dvs", 32'(DivDivisor_o), 0);
    step();
    step();
    RstN_i = 1'b1;
    div_lat = 2;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk_i);
      if (RspValid_o) seen = 1;
    end
    chk("rst_no_rsp", 32'(seen), 0);
    step();
    set_ops(1, 16'd9, 3'd2);
    Req_i = 4'b0010;
    grab(id);
    chk("post_rst_gnt", id, 1);
    step();
    Req_i = '0;
    wait_rsp();
    chk("post_rst_q", 32'(RspQ_o), 4);
    chk("post_rst_r", 32'(RspR_o), 1);
    step();
    spur = 1'b1;
    step();
    step();
    step();
    chk("spur_valid", 32'(RspValid_o), 0);
    chk("spur_busy", 32'(Busy_o), 0);
    s0 = starts;
    set_ops(1, 16'd1234, 3'd0);
    Req_i = 4'b0010;
    grab(id);
    chk("dz_gnt", id, 1);
    step();
    Req_i = '0;
`ifdef DIV_ZERO_BYPASS_EN
    chk("dz_valid", 32'(RspValid_o), 1);
    chk("dz_q", 32'(RspQ_o), 32'hFFFF);
    chk("dz_r", 32'(RspR_o), 0);
    chk("dz_flag", 32'(RspDz_o), 1);
    chk("dz_nostart", 32'(DivStart_o), 0);
    step();
    chk("dz_done", 32'(RspValid_o), 0);
    chk("dz_starts", starts - s0, 0);
`else
    chk("dz_start", 32'(DivStart_o), 1);
    wait_rsp();
    chk("dz_flag", 32'(RspDz_o), 0);
    chk("dz_q", 32'(RspQ_o), 32'hFFFF);
    step();
    chk("dz_starts", starts - s0, 1);
`endif
    for (int c = 0; c < 500; c++) begin
      logic [N-1:0] g;
      @(negedge Clk_i);
      g = Gnt_o;
      step();
      RspReady_i = ($urandom_range(0, 3) != 0);
      div_lat = $urandom_range(0, 4);
      for (int k = 0; k < N; k++) begin
        if (g[k]) begin
          if ($urandom_range(0, 1) == 1) set_ops(k, L'($urandom), LW'($urandom_range(0, 7)));
          else Req_i[k] = 1'b0;
        end else if (!Req_i[k] && $urandom_range(0, 3) == 0) begin
          set_ops(k, L'($urandom), LW'($urandom_range(0, 7)));
          Req_i[k] = 1'b1;
        end else if (Req_i[k] && $urandom_range(0, 15) == 0) Req_i[k] = 1'b0;
      end
    end
    Req_i = '0;
    RspReady_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge Clk_i);
      seen = !Busy_o && !RspValid_o;
    end
    chk("drain", 32'(seen), 1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
